// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared types, float field constants and helpers for the divider scheduler
// Contents:
//   state_t     scheduler FSM states
//   FP_*        IEEE-754 single field positions and the all-ones exponent
//   fp_is_zero  true for +0 or -0 (sign ignored)
package fdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int          FP_SIGN    = 31;
  localparam int          FP_EXP_HI  = 30;
  localparam int          FP_EXP_LO  = 23;
  localparam logic [7:0]  FP_EXP_INF = 8'hFF;

  function automatic logic fp_is_zero(input logic [31:0] w);
    return (w[FP_EXP_HI:0] == 31'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at i_ptr
// Ports:
//   i_req  request vector
//   i_ptr  highest-priority index for this decision
//   o_gnt  one-hot grant (all zero when no request)
//   o_idx  binary index of the granted bit (0 when no request)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    logic found;
    int   pos;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    pos   = 0;
    // Walk ptr, ptr+1, ... wrapping at N; the first set bit wins.
    for (int k = 0; k < N; k++) begin
      pos = (int'(i_ptr) + k) % N;
      if (!found && i_req[pos]) begin
        found      = 1'b1;
        o_gnt[pos] = 1'b1;
        o_idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fdiv_scheduler.sv
// rtl/fdiv_scheduler.sv - shares one fixed-latency float divider among N_REQ requesters
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request, one-hot accept strobe (IDLE only)
//   req_n/req_x           packed dividends/divisors, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   one-hot response valid, per-requester accept
//   rsp_res/rsp_dbz       quotient and divide-by-zero flag for the granted requester
//   busy                  high whenever not IDLE
//   div_start/div_n/div_x start pulse and held operands toward the external divider
//   div_res               divider quotient, valid DIV_LAT cycles after div_start
module fdiv_scheduler
  import fdiv_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DIV_LAT = 28,
  parameter int W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_n,
  input  logic [N_REQ*W-1:0] req_x,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_res,
  output logic               rsp_dbz,
  output logic               busy,
  output logic               div_start,
  output logic [W-1:0]       div_n,
  output logic [W-1:0]       div_x,
  input  logic [W-1:0]       div_res
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(DIV_LAT + 1);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_rsp_res;
  logic            r_rsp_dbz;
  logic [W-1:0]    r_div_n;
  logic [W-1:0]    r_div_x;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic [W-1:0]     w_n;
  logic [W-1:0]     w_x;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_n = req_n[int'(w_idx)*W +: W];
    w_x = req_x[int'(w_idx)*W +: W];
  end

  // Accept strobe is masked during reset so nothing is taken on a reset edge.
  assign req_ready = (r_state == IDLE && !rst) ? w_gnt : '0;
  assign rsp_valid = (r_state == RESP) ? (N_REQ'(1) << r_grant) : '0;
  assign rsp_res   = r_rsp_res;
  assign rsp_dbz   = r_rsp_dbz;
  assign busy      = (r_state != IDLE);
  assign div_start = (r_state == ISSUE);
  assign div_n     = r_div_n;
  assign div_x     = r_div_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_rsp_res <= '0;
      r_rsp_dbz <= 1'b0;
      r_div_n   <= '0;
      r_div_x   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_div_n <= w_n;
            r_div_x <= w_x;
            r_grant <= w_idx;
            // Zero divisor never reaches the divider; answer is signed infinity.
            if (fp_is_zero(w_x)) begin
              r_rsp_res <= {w_n[FP_SIGN] ^ w_x[FP_SIGN], FP_EXP_INF, {FP_EXP_LO{1'b0}}};
              r_rsp_dbz <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= CW'(DIV_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          // No done flag on the divider: the last counted cycle is when div_res is valid.
          if (r_cnt == CW'(1)) begin
            r_rsp_res <= div_res;
            r_rsp_dbz <= 1'b0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[r_grant]) begin
            r_state <= IDLE;
            r_ptr   <= (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_scheduler.sv
// tb/tb_fdiv_scheduler.sv - scoreboard bench for fdiv_scheduler with a fixed-latency divider model
module tb_fdiv_scheduler;

  localparam int N   = 4;
  localparam int LAT = 28;
  localparam int W   = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_n, req_x;
  logic [W-1:0]   rsp_res, div_n, div_x, div_res;
  logic           rsp_dbz, busy, div_start;

  always #5 clk = ~clk;

  fdiv_scheduler #(.N_REQ(N), .DIV_LAT(LAT), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .req_x     (req_x),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_dbz   (rsp_dbz),
    .busy      (busy),
    .div_start (div_start),
    .div_n     (div_n),
    .div_x     (div_x),
    .div_res   (div_res)
  );

  // Reference float arithmetic via double precision (operands kept in normal range).
  function automatic real f2r(input logic [31:0] w);
    logic [63:0] b;
    logic [10:0] e;
    if (w[30:0] == 31'd0) return 0.0;
    e = {3'b000, w[30:23]} + 11'd896;
    b = {w[31], e, w[22:0], 29'h0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fdiv_ref(input logic [31:0] n, input logic [31:0] x);
    if (x[30:0] == 31'd0) return {n[31] ^ x[31], 8'hFF, 23'h0};
    return r2f(f2r(n) / f2r(x));
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Divider stand-in: result visible only during the one cycle it is due, garbage otherwise.
  initial begin
    int dcyc;
    int due;
    logic [31:0] dq;
    dcyc = 0; due = -10; dq = '0;
    div_res = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      dcyc++;
      if (div_start) begin
        dq  = fdiv_ref(div_n, div_x);
        due = dcyc + LAT;
      end
      div_res = (dcyc == due) ? dq : 32'hDEADBEEF;
    end
  end

  typedef struct {
    int          g;
    logic [31:0] n, x, res, const_res;
    logic        dbz, has_const;
    int          t, due;
  } exp_t;

  exp_t        q[$];
  int          checks, errors, cyc, exp_ptr, tmo_cnt;
  logic        prev_rst, final_chk, final_done, dir_en;
  logic [31:0] dir_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: pushes on accept, compares and pops on response.
  initial begin
    exp_t e;
    logic [N-1:0] exp_rv, exp_rr;
    logic exp_ds, exp_busy;
    int g;
    checks = 0; errors = 0; cyc = 0; exp_ptr = 0; prev_rst = 1'b1; final_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        q.delete();
        exp_ptr = 0;
        chk("rst_rsp_res", 64'(rsp_res), 64'd0);
        chk("rst_rsp_dbz", 64'(rsp_dbz), 64'd0);
        chk("rst_div_n", 64'(div_n), 64'd0);
        chk("rst_div_x", 64'(div_x), 64'd0);
      end
      exp_busy = (q.size() != 0);
      exp_rv = '0;
      exp_ds = 1'b0;
      if (exp_busy) begin
        e = q[0];
        if (cyc >= e.due) exp_rv[e.g] = 1'b1;
        if (!e.dbz && cyc == e.t + 1) exp_ds = 1'b1;
        chk("div_n_hold", 64'(div_n), 64'(e.n));
        chk("div_x_hold", 64'(div_x), 64'(e.x));
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("div_start", 64'(div_start), 64'(exp_ds));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_rv != '0) begin
        chk("rsp_res", 64'(rsp_res), 64'(e.res));
        chk("rsp_dbz", 64'(rsp_dbz), 64'(e.dbz));
        if (e.has_const) chk("directed_res", 64'(rsp_res), 64'(e.const_res));
        if (rsp_ready[e.g]) begin
          void'(q.pop_front());
          exp_ptr = (e.g + 1) % N;
        end
      end
      exp_rr = '0;
      g = -1;
      if (!rst && !exp_busy) begin
        g = rr_pick(req_valid, exp_ptr);
        if (g >= 0) exp_rr[g] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      if (g >= 0) begin
        e.g = g;
        e.n = req_n[g*W +: W];
        e.x = req_x[g*W +: W];
        e.dbz = (e.x[30:0] == 31'd0);
        e.res = fdiv_ref(e.n, e.x);
        e.t = cyc;
        e.due = cyc + (e.dbz ? 1 : LAT + 2);
        e.has_const = dir_en;
        e.const_res = dir_res;
        q.push_back(e);
      end
      if (final_chk && !final_done) begin
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("timeouts", 64'(tmo_cnt), 64'd0);
        final_done = 1'b1;
      end
      prev_rst = rst;
    end
  end

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  task automatic set_ops(input int i, input bit allow_dbz);
    req_n[i*W +: W] = ($urandom % 16 == 0) ? 32'h0 : rand_fp();
    if (allow_dbz && $urandom % 8 == 0) req_x[i*W +: W] = {1'($urandom), 31'h0};
    else                                req_x[i*W +: W] = rand_fp();
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) tmo_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic run_ops(input logic [N-1:0] mask, input int nops);
    int got, left;
    logic [N-1:0] acc;
    got = 0;
    left = nops * (LAT + 10) + 50;
    req_valid = mask;
    while (got < nops && left > 0) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      left--;
      if (acc != '0) got++;
      @(posedge clk); #1;
      if (got >= nops) req_valid = '0;
      else for (int i = 0; i < N; i++) if (acc[i]) set_ops(i, 1'b0);
    end
    if (got < nops) tmo_cnt++;
    req_valid = '0;
    drain();
  endtask

  task automatic wait_neg(input logic [N-1:0] which, input bit on_rsp);
    int i;
    for (i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (on_rsp ? (rsp_valid & which) != '0 : (req_ready & which) != '0) break;
    end
    if (i == LAT + 20) tmo_cnt++;
  endtask

  task automatic directed(input logic [31:0] n, input logic [31:0] x, input logic [31:0] r);
    req_n[W-1:0] = n;
    req_x[W-1:0] = x;
    dir_res = r;
    dir_en = 1'b1;
    run_ops(4'b0001, 1);
    dir_en = 1'b0;
  endtask

  initial begin
    logic [N-1:0] acc;
    rst = 1'b1; final_chk = 1'b0; dir_en = 1'b0; dir_res = '0; tmo_cnt = 0;
    req_n = '0; req_x = '0; rsp_ready = '1;
    for (int i = 0; i < N; i++) set_ops(i, 1'b0);
    req_valid = 4'b0101;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention from reset: 0, 2, then 0 again.
    run_ops(4'b0101, 3);

    directed(32'h40C00000, 32'h40000000, 32'h40400000);
    directed(32'hBF800000, 32'h00000000, 32'hFF800000);
    directed(32'hBF800000, 32'h80000000, 32'h7F800000);

    // Backpressure on requester 1 while requester 0 waits.
    set_ops(1, 1'b0);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    wait_neg(4'b0010, 1'b0);
    @(posedge clk); #1 req_valid = 4'b0001;
    wait_neg(4'b0010, 1'b1);
    repeat (5) @(posedge clk);
    #1 rsp_ready = '1;
    run_ops(4'b0001, 1);

    // Reset during WAIT cycle 10 with requester 3 pending.
    set_ops(0, 1'b0);
    set_ops(3, 1'b0);
    req_valid = 4'b0001;
    wait_neg(4'b0001, 1'b0);
    @(posedge clk); #1 req_valid = 4'b1000;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run_ops(4'b1000, 1);

    // Fairness: everyone valid for 8 operations.
    for (int i = 0; i < N; i++) set_ops(i, 1'b1);
    run_ops(4'b1111, 8);

    // Random traffic with backpressure and dropped requests.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if ($urandom % 2 == 0) set_ops(i, 1'b1);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom % 4 == 0) begin
            set_ops(i, 1'b1);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom % 40 == 0) begin
          req_valid[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom % 4 != 0);
      end
    end
    req_valid = '0;
    rsp_ready = '1;
    drain();

    final_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdiv_scheduler.md
Name: fdiv_scheduler

Overview:
- Shares one multi-cycle single-precision float divider among N_REQ requesters.
- Round-robin arbitration; operands latched and held stable for the divider's fixed latency.
- The divider has no done flag, so its result is sampled after a counted DIV_LAT cycles.
- Divide-by-zero short-circuit: the divider is bypassed and IEEE infinity returned. Sits between the requesting compute blocks and the divider instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DIV_LAT, 28, cycles from div_start to a valid div_res (>=1)
- W, 32, float word width (IEEE-754 single; fixed 32)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-hot accept strobe
- req_n  in  N_REQ*W  dividends, requester i at [i*W +: W]
- req_x  in  N_REQ*W  divisors, same packing
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_ready  in  N_REQ  per-requester response accept
- rsp_res  out  W  quotient for the granted requester
- rsp_dbz  out  1  divide-by-zero flag, qualified by rsp_valid
- busy  out  1  high in any state except IDLE
- div_start  out  1  one-cycle start pulse to the divider
- div_n  out  W  divider dividend, registered
- div_x  out  W  divider divisor, registered
- div_res  in  W  divider quotient

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (also mid-operation):
  - state=IDLE, ptr=0, grant=0, cnt=0.
  - All outputs 0: req_ready, rsp_valid, rsp_res, rsp_dbz, busy, div_start, div_n, div_x.
  - Any in-flight divide is discarded; no response is issued for it.
- IDLE:
  - If any req_valid, choose g = first set bit searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[g]=1 combinationally this cycle only.
  - Latch req_n[g] and req_x[g] into div_n and div_x; latch grant=g.
  - If divisor is zero (bits[30:0]==0): latch rsp_res={n[31]^x[31], 8'hFF, 23'h0}, rsp_dbz=1, go RESP.
  - Otherwise go ISSUE.
  - No req_valid: stay IDLE, all strobes low.
- ISSUE: div_start=1 for exactly one cycle; cnt<=DIV_LAT; go WAIT.
- WAIT:
  - If cnt==1: rsp_res<=div_res, rsp_dbz<=0, go RESP.
  - Else cnt<=cnt-1.
  - WAIT lasts exactly DIV_LAT cycles.
- RESP:
  - rsp_valid[grant]=1; rsp_res and rsp_dbz are held stable.
  - If rsp_ready[grant]: go IDLE, ptr<=(grant+1) mod N_REQ.
  - rsp_ready on other indices is ignored.
- div_n and div_x hold from the ISSUE cycle through the end of WAIT; they change only in IDLE on accept.
- Latency, accept at cycle T, no backpressure:
  - div_start at T+1.
  - rsp_valid at T+DIV_LAT+2.
  - dbz path: rsp_valid at T+1.
- One operation in flight at a time. No new accept until the RESP handshake completes.
- A requester dropping req_valid before acceptance is legal. A request counts only when req_valid & req_ready.
- Simultaneous requests: only one is granted per accept; the others wait. ptr rotation guarantees each waits at most N_REQ-1 operations.
- Next-state and outputs use no latches. Blocking assignments appear only in combinational logic.

Decomposition:
- Package fdiv_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - Constants FP_SIGN=31, FP_EXP_HI=30, FP_EXP_LO=23, FP_EXP_INF=8'hFF.
  - Function fp_is_zero(w) returning w[30:0]==0.
- Sub-module rr_arbiter (params N; inputs req and ptr; outputs one-hot gnt and index). It is combinational and reused by other shared units.
- The scheduler instantiates rr_arbiter. The divider is instantiated outside, by the parent.

Test Plan:
- Single op: req 0, n=0x40C00000 (6.0), x=0x40000000 (2.0), DIV_LAT-cycle divider model.
  -> div_start at T+1; rsp_valid[0] at T+30; rsp_res=0x40400000; rsp_dbz=0.
- Divide by zero: n=0xBF800000, x=0x00000000.
  -> rsp_valid at T+1; rsp_res=0xFF800000; rsp_dbz=1; div_start never asserted.
  - Same with x=0x80000000 -> rsp_res=0x7F800000.
- Contention: req_valid=4'b0101 from reset (ptr=0).
  -> grant 0 first, then 2; then with 4'b0101 still asserted, grant 0 again; req_ready never multi-hot.
- Backpressure: rsp_ready[1] low for 5 cycles in RESP.
  -> rsp_valid[1] and rsp_res held 5 cycles; busy=1; no new req_ready until the handshake completes.
- Reset mid-op: assert rst at WAIT cycle 10.
  -> next cycle all outputs 0, state IDLE, ptr=0; a pending req 3 is then accepted, and the stale quotient is never returned.
- Fairness: all 4 requesters continuously valid for 8 ops.
  -> grant order 0,1,2,3,0,1,2,3; div_n and div_x stable throughout every WAIT.
